// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: merges the instruction-fetch and data command ports onto
// one shared memory port. Round-robin arbitration with a grant lock while the
// memory applies backpressure. An in-order tag FIFO steers each memory
// response back to the port that issued the command.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // instruction fetch port
  input  logic                       icache_cmd_valid,
  output logic                       icache_cmd_ready,
  input  logic [ADDR_W-1:0]          icache_cmd_payload_addr,
  output logic                       icache_rsp_valid,
  output logic [31:0]                icache_rsp_payload_data,
  // data port
  input  logic                       dcache_cmd_valid,
  output logic                       dcache_cmd_ready,
  input  logic [ADDR_W-1:0]          dcache_cmd_payload_addr,
  input  logic                       dcache_cmd_payload_wen,
  input  logic [DATA_W-1:0]          dcache_cmd_payload_wdata,
  input  logic [DATA_W/8-1:0]        dcache_cmd_payload_wstrb,
  input  logic [2:0]                 dcache_cmd_payload_size,
  output logic                       dcache_rsp_valid,
  output logic [DATA_W-1:0]          dcache_rsp_payload_data,
  // shared memory port
  output logic                       mem_cmd_valid,
  input  logic                       mem_cmd_ready,
  output logic [ADDR_W-1:0]          mem_cmd_payload_addr,
  output logic                       mem_cmd_payload_wen,
  output logic [DATA_W-1:0]          mem_cmd_payload_wdata,
  output logic [DATA_W/8-1:0]        mem_cmd_payload_wstrb,
  output logic [2:0]                 mem_cmd_payload_size,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_W-1:0]          mem_rsp_payload_data,
  // status
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  // state registers
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             lock_q, lock_d;
  src_e             locked_src_q, locked_src_d;
  src_e             last_grant_q, last_grant_d;
  logic             err_q, err_d;
  logic [DEPTH-1:0] fifo_src_q;
  logic [DEPTH-1:0] fifo_half_q;

  // combinational nets
  src_e winner;
  logic winner_req;
  logic not_full;
  logic grant_ready;
  logic mem_fire;
  logic cmd_half;
  src_e head_src;
  logic head_half;
  logic have_tag;
  logic rsp_pop;
  logic spurious;

  // Arbitration: lock overrides, ties go to the port not granted last.
  // rst_n gates the handshake outputs so nothing is offered during reset.
  always_comb begin
    winner = SRC_I;
    if (lock_q) begin
      winner = locked_src_q;
    end else if (icache_cmd_valid && dcache_cmd_valid) begin
      winner = (last_grant_q == SRC_I) ? SRC_D : SRC_I;
    end else if (dcache_cmd_valid) begin
      winner = SRC_D;
    end
    not_full         = (count_q < CNT_W'(DEPTH));
    winner_req       = (winner == SRC_D) ? dcache_cmd_valid : icache_cmd_valid;
    mem_cmd_valid    = rst_n && winner_req && not_full;
    grant_ready      = rst_n && mem_cmd_ready && not_full;
    icache_cmd_ready = grant_ready && (winner == SRC_I);
    dcache_cmd_ready = grant_ready && (winner == SRC_D);
    mem_fire         = mem_cmd_valid && mem_cmd_ready;
  end

  // Payload mux: data port forwarded as-is, fetches become 32-bit reads.
  always_comb begin
    mem_cmd_payload_addr  = icache_cmd_payload_addr;
    mem_cmd_payload_wen   = 1'b0;
    mem_cmd_payload_wdata = '0;
    mem_cmd_payload_wstrb = '0;
    mem_cmd_payload_size  = 3'd2;
    if (winner == SRC_D) begin
      mem_cmd_payload_addr  = dcache_cmd_payload_addr;
      mem_cmd_payload_wen   = dcache_cmd_payload_wen;
      mem_cmd_payload_wdata = dcache_cmd_payload_wdata;
      mem_cmd_payload_wstrb = dcache_cmd_payload_wstrb;
      mem_cmd_payload_size  = dcache_cmd_payload_size;
    end
    cmd_half = mem_cmd_payload_addr[2];
  end

  // Response routing from the FIFO head, same cycle as mem_rsp_valid.
  always_comb begin
    head_src  = src_e'(fifo_src_q[rd_ptr_q]);
    head_half = fifo_half_q[rd_ptr_q];
    have_tag  = (count_q != '0);
    rsp_pop   = rst_n && mem_rsp_valid && have_tag;
    spurious  = mem_rsp_valid && !have_tag;

    icache_rsp_valid        = rsp_pop && (head_src == SRC_I);
    dcache_rsp_valid        = rsp_pop && (head_src == SRC_D);
    dcache_rsp_payload_data = mem_rsp_payload_data;
    icache_rsp_payload_data = head_half ? mem_rsp_payload_data[32 +: 32]
                                        : mem_rsp_payload_data[0 +: 32];
  end

  // Next-state logic for occupancy, pointers, lock, grant history and error.
  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    lock_d       = lock_q;
    locked_src_d = locked_src_q;
    last_grant_d = last_grant_q;
    err_d        = err_q | spurious;

    case ({mem_fire, rsp_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (mem_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rsp_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (mem_fire) begin
      lock_d       = 1'b0;
      last_grant_d = winner;
    end else if (mem_cmd_valid && !mem_cmd_ready) begin
      lock_d       = 1'b1;
      locked_src_d = winner;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_src_q <= SRC_I;
      last_grant_q <= SRC_I;
      err_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lock_q       <= lock_d;
      locked_src_q <= locked_src_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  // Tag FIFO storage: {source, 32-bit half} written on every command fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_src_q  <= '0;
      fifo_half_q <= '0;
    end else if (mem_fire) begin
      fifo_src_q[wr_ptr_q]  <= (winner == SRC_D);
      fifo_half_q[wr_ptr_q] <= cmd_half;
    end
  end

  assign outstanding = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed scenarios followed by a random
// phase, all checked against a queue-based reference model of the arbiter.
module tb_cache_mem_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              ival = 1'b0, dval = 1'b0, dwen = 1'b0;
  logic [ADDR_W-1:0] iaddr = '0, daddr = '0;
  logic [DATA_W-1:0] dwdata = '0;
  logic [7:0]        dwstrb = '0;
  logic [2:0]        dsize = '0;
  logic              mready = 1'b0, mrsp = 1'b0;
  logic [DATA_W-1:0] mrdata = '0;

  logic              icache_cmd_ready, icache_rsp_valid;
  logic [31:0]       icache_rsp_payload_data;
  logic              dcache_cmd_ready, dcache_rsp_valid;
  logic [DATA_W-1:0] dcache_rsp_payload_data;
  logic              mem_cmd_valid, mem_cmd_payload_wen;
  logic [ADDR_W-1:0] mem_cmd_payload_addr;
  logic [DATA_W-1:0] mem_cmd_payload_wdata;
  logic [7:0]        mem_cmd_payload_wstrb;
  logic [2:0]        mem_cmd_payload_size;
  logic [2:0]        outstanding;
  logic              err;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .icache_cmd_valid         (ival),
    .icache_cmd_ready         (icache_cmd_ready),
    .icache_cmd_payload_addr  (iaddr),
    .icache_rsp_valid         (icache_rsp_valid),
    .icache_rsp_payload_data  (icache_rsp_payload_data),
    .dcache_cmd_valid         (dval),
    .dcache_cmd_ready         (dcache_cmd_ready),
    .dcache_cmd_payload_addr  (daddr),
    .dcache_cmd_payload_wen   (dwen),
    .dcache_cmd_payload_wdata (dwdata),
    .dcache_cmd_payload_wstrb (dwstrb),
    .dcache_cmd_payload_size  (dsize),
    .dcache_rsp_valid         (dcache_rsp_valid),
    .dcache_rsp_payload_data  (dcache_rsp_payload_data),
    .mem_cmd_valid            (mem_cmd_valid),
    .mem_cmd_ready            (mready),
    .mem_cmd_payload_addr     (mem_cmd_payload_addr),
    .mem_cmd_payload_wen      (mem_cmd_payload_wen),
    .mem_cmd_payload_wdata    (mem_cmd_payload_wdata),
    .mem_cmd_payload_wstrb    (mem_cmd_payload_wstrb),
    .mem_cmd_payload_size     (mem_cmd_payload_size),
    .mem_rsp_valid            (mrsp),
    .mem_rsp_payload_data     (mrdata),
    .outstanding              (outstanding),
    .err                      (err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: pending responses as a queue of {is_d, half}.
  bit [1:0] tagq[$];
  bit       m_last;   // 1 = data port won the last fire
  bit       m_lock;
  bit       m_lsrc;
  bit       m_err;
  bit       fire_i, fire_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tagq.delete();
    m_last = 1'b0;
    m_lock = 1'b0;
    m_lsrc = 1'b0;
    m_err  = 1'b0;
  endtask

  // Compare every output against the model for the current inputs, then
  // advance the model by what the coming clock edge will do.
  task automatic model_check();
    bit win, req_w, full, exp_mv;
    bit [1:0] head;
    full = (tagq.size() >= DEPTH);
    if (m_lock)            win = m_lsrc;
    else if (ival && dval) win = ~m_last;
    else                   win = dval;
    req_w  = win ? dval : ival;
    exp_mv = req_w && !full;

    chk("mem_cmd_valid", mem_cmd_valid, exp_mv);
    if (exp_mv) begin
      chk("mem_addr",  mem_cmd_payload_addr,  win ? daddr : iaddr);
      chk("mem_wen",   mem_cmd_payload_wen,   win ? dwen : 1'b0);
      chk("mem_wdata", mem_cmd_payload_wdata, win ? dwdata : 64'd0);
      chk("mem_wstrb", mem_cmd_payload_wstrb, win ? dwstrb : 8'd0);
      chk("mem_size",  mem_cmd_payload_size,  win ? dsize : 3'd2);
    end
    if (ival || dval || m_lock) begin
      chk("icache_ready", icache_cmd_ready, (!win) && mready && !full);
      chk("dcache_ready", dcache_cmd_ready, win && mready && !full);
    end
    chk("outstanding", outstanding, tagq.size());
    chk("err", err, m_err);

    if (mrsp && tagq.size() > 0) begin
      head = tagq[0];
      chk("icache_rsp_valid", icache_rsp_valid, !head[1]);
      chk("dcache_rsp_valid", dcache_rsp_valid, head[1]);
      if (head[1]) chk("dcache_rsp_data", dcache_rsp_payload_data, mrdata);
      else         chk("icache_rsp_data", icache_rsp_payload_data,
                       head[0] ? mrdata[63:32] : mrdata[31:0]);
      void'(tagq.pop_front());
    end else begin
      chk("icache_rsp_valid", icache_rsp_valid, 1'b0);
      chk("dcache_rsp_valid", dcache_rsp_valid, 1'b0);
      if (mrsp) m_err = 1'b1;
    end

    fire_i = 1'b0;
    fire_d = 1'b0;
    if (exp_mv && mready) begin
      tagq.push_back({win, win ? daddr[2] : iaddr[2]});
      m_last = win;
      m_lock = 1'b0;
      if (win) fire_d = 1'b1; else fire_i = 1'b1;
    end else if (exp_mv) begin
      m_lock = 1'b1;
      m_lsrc = win;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    at_neg();
    to_next();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ival = 1'b0; dval = 1'b0; mready = 1'b0; mrsp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    to_next();
  endtask

  task automatic drain();
    ival = 1'b0;
    dval = 1'b0;
    for (int i = 0; i < 2*DEPTH + 4 && tagq.size() > 0; i++) begin
      mrsp   = 1'b1;
      mrdata = {$urandom, $urandom};
      step();
    end
    mrsp = 1'b0;
    chk("drain_empty", outstanding, 0);
  endtask

  initial begin
    bit exp_d;
    model_reset();
    do_reset();

    // reset state
    at_neg();
    chk("reset_outstanding", outstanding, 0);
    chk("reset_err", err, 1'b0);
    chk("reset_mem_valid", mem_cmd_valid, 1'b0);
    to_next();

    // single fetch from the upper half of a doubleword
    ival = 1'b1; iaddr = 64'h8000_0004; mready = 1'b1;
    at_neg();
    chk("fetch_mem_valid", mem_cmd_valid, 1'b1);
    chk("fetch_mem_addr", mem_cmd_payload_addr, 64'h8000_0004);
    chk("fetch_mem_size", mem_cmd_payload_size, 3'd2);
    to_next();
    ival = 1'b0; mrsp = 1'b1; mrdata = 64'h1111_2222_3333_4444;
    at_neg();
    chk("fetch_outstanding_1", outstanding, 1);
    chk("fetch_rsp_valid", icache_rsp_valid, 1'b1);
    chk("fetch_rsp_data", icache_rsp_payload_data, 32'h1111_2222);
    chk("fetch_d_rsp_valid", dcache_rsp_valid, 1'b0);
    to_next();
    mrsp = 1'b0;
    at_neg();
    chk("fetch_outstanding_0", outstanding, 0);
    to_next();

    // tie after reset: D, I, D, I with D a full-strobe write
    do_reset();
    ival = 1'b1; iaddr = 64'h100;
    dval = 1'b1; daddr = 64'h208; dwen = 1'b1; dwstrb = 8'hFF;
    dwdata = 64'hDEAD_BEEF_0123_4567; dsize = 3'd3; mready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      at_neg();
      chk("tie_d_ready", dcache_cmd_ready, exp_d);
      chk("tie_i_ready", icache_cmd_ready, !exp_d);
      chk("tie_wen", mem_cmd_payload_wen, exp_d);
      to_next();
    end
    ival = 1'b0; dval = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      mrsp = 1'b1; mrdata = 64'hA5A5_0000_0000_0000 | 64'(k);
      at_neg();
      chk("tie_rsp_d", dcache_rsp_valid, exp_d);
      chk("tie_rsp_i", icache_rsp_valid, !exp_d);
      to_next();
    end
    mrsp = 1'b0;

    // backpressure lock: D stalls three cycles, then I follows
    dval = 1'b1; daddr = 64'h300; dwen = 1'b0; dwstrb = 8'h0F; dsize = 3'd1;
    ival = 1'b1; iaddr = 64'h404; mready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("bp_mem_addr", mem_cmd_payload_addr, 64'h300);
      chk("bp_i_ready", icache_cmd_ready, 1'b0);
      to_next();
    end
    mready = 1'b1;
    at_neg();
    chk("bp_d_fire", dcache_cmd_ready, 1'b1);
    to_next();
    dval = 1'b0;
    at_neg();
    chk("bp_i_fire", icache_cmd_ready, 1'b1);
    chk("bp_i_addr", mem_cmd_payload_addr, 64'h404);
    to_next();
    drain();

    // lock holds I even when D joins and would otherwise win the tie
    ival = 1'b1; iaddr = 64'h500; mready = 1'b0;
    step();
    dval = 1'b1; daddr = 64'h600;
    at_neg();
    chk("lock_keeps_i", mem_cmd_payload_addr, 64'h500);
    to_next();
    mready = 1'b1;
    step();
    step();
    drain();

    // full FIFO blocks issue until the cycle after a response
    dval = 1'b1; daddr = 64'h700; ival = 1'b0; mready = 1'b1;
    repeat (DEPTH) step();
    ival = 1'b1; mrsp = 1'b1; mrdata = 64'h7777;
    at_neg();
    chk("full_outstanding", outstanding, DEPTH);
    chk("full_mem_valid", mem_cmd_valid, 1'b0);
    chk("full_i_ready", icache_cmd_ready, 1'b0);
    chk("full_d_ready", dcache_cmd_ready, 1'b0);
    to_next();
    mrsp = 1'b0;
    at_neg();
    chk("full_resume", mem_cmd_valid, 1'b1);
    to_next();
    drain();

    // spurious response sets a sticky error
    mrsp = 1'b1; mrdata = 64'h5;
    at_neg();
    chk("spur_i_rsp", icache_rsp_valid, 1'b0);
    chk("spur_d_rsp", dcache_rsp_valid, 1'b0);
    to_next();
    mrsp = 1'b0;
    step();
    step();
    chk("spur_sticky", err, 1'b1);

    // build outstanding = 2 with a lock, then reset between edges
    dval = 1'b1; daddr = 64'h800; ival = 1'b0; mready = 1'b1;
    step();
    dval = 1'b0; ival = 1'b1; iaddr = 64'h900;
    step();
    dval = 1'b1; mready = 1'b0;
    step();
    chk("pre_rst_outstanding", outstanding, 2);
    mready = 1'b1; mrsp = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_valid", mem_cmd_valid, 1'b0);
    chk("rst_i_ready", icache_cmd_ready, 1'b0);
    chk("rst_d_ready", dcache_cmd_ready, 1'b0);
    chk("rst_i_rsp", icache_rsp_valid, 1'b0);
    chk("rst_d_rsp", dcache_rsp_valid, 1'b0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    mrsp = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1;
    model_check();
    chk("post_rst_tie_d", mem_cmd_payload_addr, 64'h800);
    to_next();
    drain();

    // random traffic with protocol-legal holding of valid/payload
    ival = 1'b0; dval = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!ival || fire_i) begin
        ival  = 1'($urandom_range(0, 1));
        iaddr = {$urandom, $urandom};
      end
      if (!dval || fire_d) begin
        dval   = 1'($urandom_range(0, 1));
        daddr  = {$urandom, $urandom};
        dwen   = 1'($urandom_range(0, 1));
        dwdata = {$urandom, $urandom};
        dwstrb = 8'($urandom);
        dsize  = 3'($urandom_range(0, 7));
      end
      mready = ($urandom_range(0, 3) != 0);
      mrsp   = (tagq.size() > 0) && ($urandom_range(0, 2) != 0);
      mrdata = {$urandom, $urandom};
      fire_i = 1'b0;
      fire_d = 1'b0;
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
